// File: rtl/sha3_digest_out.sv
// SHA-3 digest squeeze: captures lanes 0..7 and streams the leading d bits as 64-bit words.
// Define SHA3_DIGEST_BYTESWAP_EN to emit each word byte-reversed (hex-string order).
module sha3_digest_out (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [1599:0] state_in,
    input  logic [1:0]    mode,
    output logic [63:0]   dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_last,
    output logic [7:0]    dout_keep
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [7:0][63:0] lane_q;
    logic [1:0]       mode_q;
    logic [2:0]       idx_q;
    logic [2:0]       idx_d;
    logic [2:0]       last_idx;
    logic             capture;
    logic [63:0]      word;
    logic             unused_lanes;

    // Only the first 512 bits can ever reach the output.
    assign unused_lanes = ^state_in[1599:512];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            lane_q  <= '0;
            mode_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (capture) begin
                lane_q <= state_in[511:0];
                mode_q <= mode;
            end
        end
    end

    always_comb begin
        case (mode_q)
            2'b10:   last_idx = 3'd5;
            2'b11:   last_idx = 3'd7;
            default: last_idx = 3'd3;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        s_ready    = 1'b0;
        dout_valid = 1'b0;
        dout_last  = 1'b0;
        capture    = 1'b0;
        unique case (state_q)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    capture = 1'b1;
                    state_d = SEND;
                    idx_d   = 3'd0;
                end
            end
            SEND: begin
                dout_valid = 1'b1;
                dout_last  = (idx_q == last_idx);
                if (dout_ready) begin
                    if (dout_last) begin
                        state_d = IDLE;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
        endcase
    end

    assign word = lane_q[idx_q];

    // 224 = 3*64 + 32: only half of the final word belongs to the digest.
    always_comb begin
        dout      = 64'h0;
        dout_keep = 8'h00;
        if (state_q == SEND) begin
`ifdef SHA3_DIGEST_BYTESWAP_EN
            for (int k = 0; k < 8; k++) begin
                dout[8*k +: 8] = word[8*(7-k) +: 8];
            end
            dout_keep = (dout_last && mode_q == 2'b00) ? 8'hF0 : 8'hFF;
`else
            dout      = word;
            dout_keep = (dout_last && mode_q == 2'b00) ? 8'h0F : 8'hFF;
`endif
        end
    end

endmodule
